fp_clk_divider: RTL and testbench



---
 rtl/fp_clk_divider_pkg.sv | 35 +++
 rtl/fp_clk_divider.sv | 82 ++++++++
 tb/tb_fp_clk_divider.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fp_clk_divider_pkg.sv
// Shared constants and half-period calculation for the fractional clock divider.
// The accumulator is 24.16 fixed point: 24 integer bits and 16 fraction bits.
package fp_clk_divider_pkg;

  localparam int unsigned ACC_INT_BITS  = 24;
  localparam int unsigned ACC_FRAC_BITS = 16;
  localparam int unsigned ACC_W         = ACC_INT_BITS + ACC_FRAC_BITS;

  typedef logic [ACC_W-1:0] acc_t;

  // One clk_in cycle expressed in 24.16.
  localparam acc_t ACC_STEP = acc_t'(64'd1 << ACC_FRAC_BITS);

  // Untruncated half period in 24.16; lets callers detect integer-part overflow.
  function automatic longint unsigned calc_half_period_raw(
    input longint unsigned in_hz,
    input longint unsigned out_hz,
    input bit              use_frac
  );
    longint unsigned den;
    den = out_hz << 1;
    if (den == 64'd0) return 64'd0;
    if (use_frac) return ((in_hz << ACC_FRAC_BITS) + out_hz) / den;
    return ((in_hz + out_hz) / den) << ACC_FRAC_BITS;
  endfunction

  function automatic acc_t calc_half_period(
    input longint unsigned in_hz,
    input longint unsigned out_hz,
    input bit              use_frac
  );
    return ACC_W'(calc_half_period_raw(in_hz, out_hz, use_frac));
  endfunction

endpackage

// File: rtl/fp_clk_divider.sv
// Fractional clock synthesizer: 50:50 clk_out plus single-cycle edge strobes.
// Define FP_CLK_DIVIDER_REPORT_EN to print an elaboration-time accuracy report.
module fp_clk_divider
  import fp_clk_divider_pkg::*;
#(
  parameter int unsigned USE_FLOATING_DIVIDE = 1,
  parameter int unsigned INPUT_CLK_HZ        = 100000000,
  parameter int unsigned OUTPUT_CLK_HZ       = 3579545
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic clk_out,
  output logic clk_p0,
  output logic clk_p180
);

  localparam longint unsigned HALF_RAW =
    calc_half_period_raw(64'(INPUT_CLK_HZ), 64'(OUTPUT_CLK_HZ), USE_FLOATING_DIVIDE != 0);
  localparam acc_t HALF =
    calc_half_period(64'(INPUT_CLK_HZ), 64'(OUTPUT_CLK_HZ), USE_FLOATING_DIVIDE != 0);

  if (HALF_RAW < (64'd2 << ACC_FRAC_BITS)) begin : g_half_too_short
    $error("fp_clk_divider: half period below 2 cycles (INPUT_CLK_HZ=%0d, OUTPUT_CLK_HZ=%0d)",
           INPUT_CLK_HZ, OUTPUT_CLK_HZ);
  end

  if ((HALF_RAW >> ACC_FRAC_BITS) >= (64'd1 << ACC_INT_BITS)) begin : g_half_too_long
    $error("fp_clk_divider: half period exceeds 24-bit integer range (INPUT_CLK_HZ=%0d, OUTPUT_CLK_HZ=%0d)",
           INPUT_CLK_HZ, OUTPUT_CLK_HZ);
  end

`ifdef FP_CLK_DIVIDER_REPORT_EN
  localparam longint unsigned OUT_SAFE  = (OUTPUT_CLK_HZ == 0) ? 64'd1 : 64'(OUTPUT_CLK_HZ);
  localparam longint unsigned IN_SAFE   = (INPUT_CLK_HZ == 0) ? 64'd1 : 64'(INPUT_CLK_HZ);
  localparam longint unsigned HALF_SAFE = (HALF == '0) ? 64'd1 : 64'(HALF);
  // Achieved frequency in hundredths of a hertz.
  localparam longint unsigned ACH_CHZ   = ((64'(INPUT_CLK_HZ) * 64'd100) << ACC_FRAC_BITS) / (HALF_SAFE << 1);
  localparam longint          DIFF_CHZ  = longint'(ACH_CHZ) - longint'(OUT_SAFE * 64'd100);
  localparam longint          PPB       = (DIFF_CHZ * 64'sd10000000) / longint'(OUT_SAFE);
  localparam longint unsigned PPB_ABS   = (PPB < 0) ? 64'(-PPB) : 64'(PPB);
  localparam longint unsigned JITTER_NS =
    (HALF[ACC_FRAC_BITS-1:0] != '0) ? (64'd1000000000 / IN_SAFE) : 64'd0;

  if (1) begin : g_report
    $info("fp_clk_divider: H=%0d.%05d (0x%010h in 24.16), f_out=%0d.%02d Hz, error %s%0d.%03d ppm, jitter %0d ns",
          HALF[ACC_W-1:ACC_FRAC_BITS], (64'(HALF[ACC_FRAC_BITS-1:0]) * 64'd100000) >> ACC_FRAC_BITS,
          HALF, ACH_CHZ / 64'd100, ACH_CHZ % 64'd100,
          (PPB < 0) ? "-" : "+", PPB_ABS / 64'd1000, PPB_ABS % 64'd1000, JITTER_NS);
  end
`endif

  acc_t             acc;
  logic [ACC_W:0]   acc_sum;
  acc_t             acc_wrap;
  logic             wrap;

  // acc stays below HALF, so the wrapped remainder always fits in ACC_W bits.
  always_comb begin
    acc_sum  = {1'b0, acc} + {1'b0, ACC_STEP};
    acc_wrap = ACC_W'(acc_sum - {1'b0, HALF});
    wrap     = (acc_sum >= {1'b0, HALF});
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc      <= '0;
      clk_out  <= 1'b0;
      clk_p0   <= 1'b0;
      clk_p180 <= 1'b0;
    end else if (wrap) begin
      acc      <= acc_wrap;
      clk_out  <= ~clk_out;
      clk_p0   <= ~clk_out;
      clk_p180 <= clk_out;
    end else begin
      acc      <= ACC_W'(acc_sum);
      clk_p0   <= 1'b0;
      clk_p180 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_clk_divider.sv
// Scoreboard bench for fp_clk_divider: three configurations share clock and reset.
// Expected edge k of a run lands at cycle ceil(k*H/65536) after reset release.
module tb_fp_clk_divider;

  localparam int unsigned ND   = 3;
  localparam int unsigned WIN1 = 20000;
  localparam int unsigned WIN2 = 300;

  typedef struct packed {
    int unsigned cyc;
    logic        rise;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [ND-1:0] co, p0, p180, prev;
  logic          rst_s = 1'b1;
  int unsigned   k = 0;
  int unsigned   rises   [ND];
  int unsigned   exp_rise[ND];
  int unsigned   n_vec = 0;
  int unsigned   n_miss = 0;
  ev_t           q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  fp_clk_divider u_frac (
    .clk_in(clk), .rst_in(rst), .clk_out(co[0]), .clk_p0(p0[0]), .clk_p180(p180[0])
  );
  fp_clk_divider #(.USE_FLOATING_DIVIDE(0)) u_int (
    .clk_in(clk), .rst_in(rst), .clk_out(co[1]), .clk_p0(p0[1]), .clk_p180(p180[1])
  );
  fp_clk_divider #(.OUTPUT_CLK_HZ(25000000)) u_fast (
    .clk_in(clk), .rst_in(rst), .clk_out(co[2]), .clk_p0(p0[2]), .clk_p180(p180[2])
  );

  // Half periods in 24.16 worked out by hand for each instance.
  function automatic longint unsigned half_of(input int unsigned d);
    case (d)
      0:       return 64'd915424;
      1:       return 64'd14 * 64'd65536;
      default: return 64'd2 * 64'd65536;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned sb_size(input int unsigned d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ev_t sb_peek(input int unsigned d, input int unsigned i);
    case (d)
      0:       return q0[i];
      1:       return q1[i];
      default: return q2[i];
    endcase
  endfunction

  task automatic sb_push(input int unsigned d, input ev_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int unsigned d, output ev_t e);
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic sb_clear(input int unsigned d);
    case (d)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Called as reset is released: queue every edge due within the horizon.
  task automatic sb_load(input int unsigned horizon, input int unsigned window);
    longint unsigned n, t, h;
    ev_t e;
    for (int unsigned d = 0; d < ND; d++) begin
      sb_clear(d);
      exp_rise[d] = 0;
      h = half_of(d);
      n = 64'd1;
      t = (n * h + 64'd65535) / 64'd65536;
      while (t <= 64'(horizon)) begin
        e.cyc  = 32'(t);
        e.rise = n[0];
        sb_push(d, e);
        if (n[0] && t <= 64'(window)) exp_rise[d]++;
        n++;
        t = (n * h + 64'd65535) / 64'd65536;
      end
    end
  endtask

  // Any queued edge at or before the current cycle was never produced.
  task automatic sb_flush();
    int unsigned missed;
    for (int unsigned d = 0; d < ND; d++) begin
      missed = 0;
      for (int unsigned i = 0; i < sb_size(d); i++)
        if (sb_peek(d, i).cyc <= k) missed++;
      chk($sformatf("missed_edges[%0d]", d), 64'(missed), 64'd0);
      sb_clear(d);
    end
  endtask

  task automatic sb_check(input int unsigned d);
    ev_t e;
    chk($sformatf("edge_expected[%0d]", d), 64'(sb_size(d) != 0), 64'd1);
    if (sb_size(d) != 0) begin
      sb_pop(d, e);
      chk($sformatf("edge_cycle[%0d]", d), 64'(k), 64'(e.cyc));
      chk($sformatf("edge_is_rise[%0d]", d), 64'(p0[d]), 64'(e.rise));
    end
  endtask

  // One clk_in cycle: track reset and cycle index at the edge, sample outputs mid-cycle.
  task automatic step();
    @(posedge clk);
    rst_s = rst;
    k = rst ? 0 : k + 1;
    @(negedge clk);
    for (int unsigned d = 0; d < ND; d++) begin
      if (rst_s) begin
        chk($sformatf("reset_state[%0d]", d), 64'({co[d], p0[d], p180[d]}), 64'd0);
        rises[d] = 0;
      end else begin
        chk($sformatf("strobe_vs_clk[%0d]", d), 64'({p0[d], p180[d]}),
            64'({co[d] & ~prev[d], ~co[d] & prev[d]}));
        if (p0[d] | p180[d]) sb_check(d);
        if (p0[d]) rises[d]++;
      end
      prev[d] = co[d];
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();

    rst = 1'b0;
    sb_load(WIN1 + 100, WIN1);
    repeat (WIN1) step();
    for (int unsigned d = 0; d < ND; d++)
      chk($sformatf("rise_count_long[%0d]", d), 64'(rises[d]), 64'(exp_rise[d]));

    // Reset mid-period while the fractional output is high.
    for (int i = 0; i < 64 && co[0] !== 1'b1; i++) step();
    chk("clk_high_before_reset", 64'(co[0]), 64'd1);
    sb_flush();
    rst = 1'b1;
    repeat (3) step();

    rst = 1'b0;
    sb_load(WIN2, WIN2);
    repeat (WIN2) step();
    sb_flush();
    for (int unsigned d = 0; d < ND; d++)
      chk($sformatf("rise_count_short[%0d]", d), 64'(rises[d]), 64'(exp_rise[d]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
